// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined logarithmic shifter/rotator with valid/ready handshake,
// carry-out, reserved-op flagging and a running signature of delivered results.
module shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  logic [2:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_carry,
  output logic                       out_illegal,
  output logic [WIDTH-1:0]           sig,
  output logic [15:0]                count
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CHUNK = (SHW + STAGES - 1) / STAGES;

  localparam logic [2:0] OP_SHL = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [2:0] op,
                                                input int sh);
    logic [WIDTH-1:0] r;
    r = d;
    case (op)
      OP_SHL:  r = d << sh;
      OP_SHR:  r = d >> sh;
      OP_SRA:  r = $signed(d) >>> sh;
      OP_ROL:  r = (d << sh) | (d >> (WIDTH - sh));
      OP_ROR:  r = (d >> sh) | (d << (WIDTH - sh));
      default: r = d;
    endcase
    return r;
  endfunction

  // Amount bit k is owned by stage k/CHUNK; stages past the top amount bit pass through.
  function automatic logic [WIDTH-1:0] apply_stage(input logic [WIDTH-1:0] d,
                                                   input logic [2:0] op,
                                                   input logic [SHW-1:0] amt,
                                                   input int stage);
    logic [WIDTH-1:0] r;
    r = d;
    for (int k = 0; k < SHW; k++) begin
      if (((k / CHUNK) == stage) && amt[k]) r = shift_by(r, op, 1 << k);
    end
    return r;
  endfunction

  logic              e_illegal;
  logic              e_carry;
  logic [SHW-1:0]    e_amt;
  logic [SHW-1:0]    neg_amt;
  logic [SHW-1:0]    amt_m1;

  // Carry is resolved from the unshifted operand so it can ride along with the beat.
  always_comb begin
    e_illegal = (in_op > OP_ROR);
    e_amt     = e_illegal ? '0 : in_amt;
    neg_amt   = ~in_amt + 1'b1;
    amt_m1    = in_amt - 1'b1;
    e_carry   = 1'b0;
    if (!e_illegal && (in_amt != '0)) begin
      case (in_op)
        OP_SHL, OP_ROL: e_carry = in_data[neg_amt];
        default:        e_carry = in_data[amt_m1];
      endcase
    end
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] cry;
  logic [STAGES-1:0] ill;
  logic [WIDTH-1:0]  dat   [STAGES];
  logic [SHW-1:0]    amt_q [STAGES];
  logic [2:0]        op_q  [STAGES];

  logic advance;
  logic accept;
  logic xfer;

  assign advance = !vld[STAGES-1] || out_ready;
  assign in_ready = rst_n && !flush && advance;
  assign accept   = in_valid && in_ready;
  assign xfer     = vld[STAGES-1] && out_ready && !flush;

  assign out_valid   = vld[STAGES-1];
  assign out_data    = dat[STAGES-1];
  assign out_carry   = cry[STAGES-1];
  assign out_illegal = ill[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      cry <= '0;
      ill <= '0;
      for (int s = 0; s < STAGES; s++) begin
        dat[s]   <= '0;
        amt_q[s] <= '0;
        op_q[s]  <= '0;
      end
    end else if (flush) begin
      vld <= '0;
    end else if (advance) begin
      vld[0]   <= accept;
      cry[0]   <= e_carry;
      ill[0]   <= e_illegal;
      dat[0]   <= apply_stage(in_data, in_op, e_amt, 0);
      amt_q[0] <= e_amt;
      op_q[0]  <= in_op;
      for (int s = 1; s < STAGES; s++) begin
        vld[s]   <= vld[s-1];
        cry[s]   <= cry[s-1];
        ill[s]   <= ill[s-1];
        dat[s]   <= apply_stage(dat[s-1], op_q[s-1], amt_q[s-1], s);
        amt_q[s] <= amt_q[s-1];
        op_q[s]  <= op_q[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig   <= '0;
      count <= '0;
    end else if (xfer) begin
      sig   <= {sig[WIDTH-2:0], sig[WIDTH-1]} ^ dat[STAGES-1];
      count <= count + 16'd1;
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - directed and randomized checks of shift_pipe (WIDTH=32, STAGES=2)
// against a bit-level reference model and result scoreboard.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_carry;
  logic        out_illegal;
  logic [31:0] sig;
  logic [15:0] count;

  shift_pipe #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_illegal(out_illegal), .sig(sig), .count(count)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  int           pops = 0;
  bit           acc_seen;
  logic [33:0]  q[$];
  logic [31:0]  m_sig = '0;
  logic [15:0]  m_count = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result bit i is traced back to its source bit by index arithmetic; returns {illegal, carry, data}.
  function automatic logic [33:0] ref_model(input logic [31:0] d, input int amt, input int op);
    logic [31:0] r;
    logic        c;
    int          src;
    r = d;
    c = 1'b0;
    if (op > 4) return {1'b1, 1'b0, d};
    if (amt == 0) return {2'b00, d};
    for (int i = 0; i < 32; i++) begin
      case (op)
        0: begin src = i - amt; r[i] = (src >= 0) ? d[src] : 1'b0; end
        1: begin src = i + amt; r[i] = (src < 32) ? d[src] : 1'b0; end
        2: begin src = i + amt; r[i] = (src < 32) ? d[src] : d[31]; end
        3: r[i] = d[(i - amt + 32) % 32];
        default: r[i] = d[(i + amt) % 32];
      endcase
    end
    case (op)
      0: c = d[32 - amt];
      1, 2: c = d[amt - 1];
      3: c = r[0];
      default: c = r[31];
    endcase
    return {1'b0, c, r};
  endfunction

  task automatic sample();
    logic [33:0] e;
    @(negedge clk);
    acc_seen = 1'b0;
    check("sig", sig, m_sig);
    check("count", count, m_count);
    if (flush) begin
      check("flush_in_ready", in_ready, 0);
      q.delete();
    end else begin
      if (rst_n && out_valid && out_ready) begin
        check("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("sb_data", out_data, e[31:0]);
          check("sb_carry", out_carry, e[32]);
          check("sb_illegal", out_illegal, e[33]);
          m_sig = {m_sig[30:0], m_sig[31]} ^ e[31:0];
          m_count++;
          pops++;
        end
      end
      if (rst_n && in_valid && in_ready) begin
        acc_seen = 1'b1;
        q.push_back(ref_model(in_data, int'(in_amt), int'(in_op)));
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] d, input int amt, input int op,
                          input logic [31:0] xd, input logic xc, input logic xi);
    out_ready = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = 5'(amt);
    in_op     = 3'(op);
    sample();
    check({tag, "_accept"}, acc_seen, 1);
    advance();
    in_valid = 1'b0;
    sample();
    check({tag, "_lat1"}, out_valid, 0);
    advance();
    sample();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, xd);
    check({tag, "_carry"}, out_carry, xc);
    check({tag, "_illegal"}, out_illegal, xi);
    advance();
  endtask

  initial begin
    logic [31:0] sd[4];
    logic [31:0] held;
    logic [31:0] s0;
    logic [15:0] c0;
    int          idx;
    int          r;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0;
    out_ready = 1'b0;

    sample();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    advance();
    rst_n = 1'b1;
    sample();
    check("post_rst_in_ready", in_ready, 1);
    advance();

    directed("shl31", 32'h0000_0001, 31, 0, 32'h8000_0000, 1'b0, 1'b0);
    directed("sra4",  32'h8000_0000, 4, 2, 32'hF800_0000, 1'b0, 1'b0);
    directed("shr4",  32'h8000_0000, 4, 1, 32'h0800_0000, 1'b0, 1'b0);
    directed("rol1",  32'h8000_0001, 1, 3, 32'h0000_0003, 1'b1, 1'b0);
    directed("op6",   32'h1234_5678, 7, 6, 32'h1234_5678, 1'b0, 1'b1);
    directed("amt0",  32'hDEAD_BEEF, 0, 4, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Back-pressure: four beats against a stalled output.
    for (int i = 0; i < 4; i++) sd[i] = $urandom;
    out_ready = 1'b0; idx = 0; pops = 0; c0 = m_count; held = '0;
    for (int c = 0; c < 7; c++) begin
      in_valid = (idx < 4);
      in_data  = (idx < 4) ? sd[idx] : 32'h0;
      in_amt   = 5'(idx + 3);
      in_op    = 3'(idx % 5);
      sample();
      if (acc_seen) idx++;
      if (c >= 2) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        if (c == 2) held = out_data;
        else check("stall_hold", out_data, held);
      end
      advance();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && pops < 4; c++) begin
      in_valid = (idx < 4);
      in_data  = (idx < 4) ? sd[idx] : 32'h0;
      in_amt   = 5'(idx + 3);
      in_op    = 3'(idx % 5);
      sample();
      if (acc_seen) idx++;
      advance();
    end
    in_valid = 1'b0;
    check("stall_pops", pops, 4);
    check("stall_accepted", idx, 4);
    sample();
    check("stall_count", count, c0 + 16'd4);
    advance();

    // Flush with two beats in flight and a third offered in the flush cycle.
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1; in_data = $urandom; in_amt = 5'(b + 1); in_op = 3'd0;
      sample();
      advance();
    end
    flush = 1'b1; in_data = 32'hCAFE_F00D;
    s0 = sig; c0 = count;
    sample();
    advance();
    flush = 1'b0; in_valid = 1'b0;
    sample();
    check("flush_out_valid", out_valid, 0);
    check("flush_sig", sig, s0);
    check("flush_count", count, c0);
    advance();
    sample();
    check("flush_drained", out_valid, 0);
    advance();
    directed("post_flush_ror1", 32'h0000_0001, 1, 4, 32'h8000_0000, 1'b1, 1'b0);

    // Randomized traffic with occasional flush.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom % 10);
      in_valid  = ($urandom % 4) != 0;
      in_data   = $urandom;
      in_amt    = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom % 32);
      in_op     = (($urandom % 8) == 0) ? 3'(5 + $urandom % 3) : 3'($urandom % 5);
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 50) == 0;
      sample();
      advance();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      sample();
      advance();
    end
    check("rand_drained", q.size(), 0);

    // Half-cycle reset pulse mid-stream.
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1; in_data = $urandom | 32'h1; in_amt = 5'd1; in_op = 3'd3;
      sample();
      advance();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    q.delete(); m_sig = '0; m_count = '0;
    #2;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_carry", out_carry, 0);
    check("arst_out_illegal", out_illegal, 0);
    check("arst_sig", sig, 0);
    check("arst_count", count, 0);
    check("arst_in_ready", in_ready, 0);
    #3;
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      sample();
      check("arst_no_stale", out_valid, 0);
      advance();
    end
    directed("post_rst_sra", 32'h8000_00F0, 5, 2, 32'hFC00_0007, 1'b1, 1'b0);
    sample();
    check("post_rst_count", count, 1);
    advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width; power of two, 8..64.
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth; 1..$clog2(WIDTH). Derived localparam SHW = $clog2(WIDTH).
REQ-003 SHALL have ports, one per line:
 clk  in  1  single clock, rising edge.
 rst_n  in  1  reset, asynchronous assert, active-low.
 flush  in  1  synchronous pipeline clear.
 in_valid  in  1  input beat offered.
 in_ready  out  1  input beat accepted when in_valid && in_ready.
 in_data  in  WIDTH  operand.
 in_amt  in  SHW  shift/rotate amount.
 in_op  in  3  0 SHL, 1 SHR, 2 SRA, 3 ROL, 4 ROR, 5-7 reserved.
 out_valid  out  1  result beat present.
 out_ready  in  1  result taken when out_valid && out_ready.
 out_data  out  WIDTH  result.
 out_carry  out  1  last bit shifted or rotated out.
 out_illegal  out  1  beat carried a reserved op.
 sig  out  WIDTH  running signature of transferred results.
 count  out  16  number of transferred results.

Function
REQ-004 SHALL implement a logarithmic shifter split across STAGES register stages; stage i applies amount bits [i*ceil(SHW/STAGES) +: ceil(SHW/STAGES)], clipped to SHW-1.
REQ-005 SHALL have latency exactly STAGES cycles from accept to out_valid when not stalled, with throughput of one beat per cycle.
REQ-006 SHL/SHR SHALL zero-fill; SRA SHALL fill with in_data[WIDTH-1]; ROL/ROR SHALL rotate modulo WIDTH.
REQ-007 in_amt == 0 SHALL return in_data unchanged with out_carry = 0, for every op.
REQ-008 out_carry SHALL be, for amt > 0: SHL in_data[WIDTH-amt]; SHR/SRA in_data[amt-1]; ROL out_data[0]; ROR out_data[WIDTH-1]. It SHALL be computed at entry and pipelined with the beat.
REQ-009 Reserved ops SHALL pass in_data unchanged with out_carry = 0 and out_illegal = 1; out_illegal SHALL be 0 for ops 0-4.
REQ-010 Stall: when out_valid && !out_ready, all stages SHALL hold and in_ready SHALL be 0; otherwise in_ready SHALL be 1 (in_ready = !out_valid || out_ready, flush excepted).
REQ-011 A bubble (no accept) SHALL propagate as an invalid stage; out_valid SHALL be 0 when the last stage is empty.
REQ-012 out_data, out_carry and out_illegal SHALL be stable while out_valid && !out_ready.
REQ-013 On each output transfer: sig <= {sig[WIDTH-2:0], sig[WIDTH-1]} ^ out_data; count <= count + 1, wrapping 0xFFFF to 0.
REQ-014 flush SHALL invalidate all stages on the next edge, force in_ready = 0 that cycle, and take priority over an accept and a transfer in the same cycle. A beat presented under flush SHALL be dropped. sig and count SHALL be unchanged by flush.
REQ-015 Simultaneous accept and transfer while the pipe is full SHALL advance all stages with no loss or duplication.

Reset
REQ-016 rst_n low SHALL asynchronously clear all stage valids, out_valid, out_data, out_carry, out_illegal, sig and count to 0.
REQ-017 While rst_n is low, in_ready SHALL be 0. After release it SHALL be 1 from the first edge.
REQ-018 Reset asserted mid-stream SHALL discard all in-flight beats. No partial result SHALL appear after release.

Verification (WIDTH=32, STAGES=2)
REQ-019 SHL 0x00000001 amt 31 -> out_data 0x80000000, out_carry 0, out_valid exactly 2 cycles after accept.
REQ-020 SRA 0x80000000 amt 4 -> 0xF8000000, carry 0. SHR same inputs -> 0x08000000, carry 0. ROL 0x80000001 amt 1 -> 0x00000003, carry 1.
REQ-021 Stream 4 beats, hold out_ready low 5 cycles -> in_ready drops once the pipe is full, out_data holds, all 4 results emerge in order with no loss, count = 4.
REQ-022 Op 6 with data 0x12345678 amt 7 -> 0x12345678, out_illegal 1, carry 0.
REQ-023 flush with 2 beats in flight -> out_valid 0 on the next cycle, sig and count unchanged, and the next accepted beat completes normally.
REQ-024 Drop rst_n for half a cycle mid-stream -> outputs are 0 immediately, no stale beat after release, count restarts from 0.
